pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Write-side transmitter for the correction frame buffer.
- Accepts a camera-style stream (vsync/href/data-enable) in the clk0 domain and produces the write stream dIn/dInValid.
- Guarantees exactly IMG_W*IMG_H write beats per accepted frame, in raster order, so the buffer's linear write address lines up with the location ROM.
- Flags malformed frames and pulses frame_done so the read side may start.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 400, lines per frame; IMG_W*IMG_H must be at most 2^18.
- PAD_VALUE, 8'h00, byte emitted when padding short lines.

Ports:
- clk0  in  1  write-domain clock.
- rst  in  1  reset.
- frame_en  in  1  permit capture of the next frame.
- cam_vsync  in  1  frame sync, high between frames.
- cam_href  in  1  line active.
- cam_de  in  1  pixel valid while href high.
- cam_data  in  8  pixel byte.
- dIn  out  8  write data to frame buffer.
- dInValid  out  1  write strobe, one beat per pixel.
- busy  out  1  frame capture in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_err  out  1  sticky per frame: line length or frame length error.
- pix_cnt  out  18  beats written in current frame.

Behaviour:
- Reset rst is asynchronous, active-high; clock is clk0. All cam_* inputs are synchronous to clk0; no CDC inside the block.
- Reset values: dIn=0, dInValid=0, busy=0, frame_done=0, frame_err=0, pix_cnt=0, state=IDLE.
- Registered vsync_d and href_d provide edge detection.
  - vsync fall = vsync_d & ~cam_vsync; vsync rise = ~vsync_d & cam_vsync.
  - href fall = href_d & ~cam_href.
- Counters: col (0..IMG_W) and row (0..IMG_H-1).
- Output timing:
  - Input sampled at edge N produces dIn/dInValid valid after edge N, i.e. 1-cycle latency.
  - pix_cnt increments on the same edge that asserts dInValid.
  - dInValid is low in every cycle with no beat.
  - dIn holds its last value when idle.
- FSM states: IDLE, ACTIVE, PAD, DONE. busy=1 in ACTIVE, PAD and DONE.
- IDLE:
  - vsync fall with frame_en=1 -> ACTIVE; clear col, row, pix_cnt, frame_err.
  - vsync fall with frame_en=0 -> frame skipped, stay IDLE.
  - frame_en is sampled only at vsync fall.
- ACTIVE, on href & de:
  - col<IMG_W -> beat with dIn=cam_data; col+1.
  - col==IMG_W -> pixel dropped; frame_err=1.
- ACTIVE, on href fall:
  - col==IMG_W -> col=0, row+1. If row was IMG_H-1 -> DONE.
  - col<IMG_W (including col==0) -> frame_err=1 and short-line handling (see Optional Feature).
- PAD:
  - One beat per cycle with dIn=PAD_VALUE until col==IMG_W.
  - Then col=0, row+1 -> DONE if row was IMG_H-1, else ACTIVE.
  - Input pixels during PAD are dropped and set frame_err=1.
  - An href fall seen during PAD is ignored; no row increment.
- Early frame end: vsync rise in ACTIVE or PAD before the last row completes -> frame_err=1, no further beats, -> DONE.
- A vsync fall while busy is ignored.
- DONE: frame_done=1 for exactly one cycle -> IDLE. pix_cnt and frame_err hold until the next accepted frame.
- Reset mid-frame: all state returns to reset values immediately; capture resumes only at the next vsync fall.

Optional Feature:
- Macro: LINE_PAD_EN.
- Defined: a short line enters PAD and is completed with PAD_VALUE, so a full frame always yields IMG_W*IMG_H beats.
- Undefined: PAD state is not compiled. A short line sets frame_err, col=0, row+1 (line truncated), and the frame yields fewer beats; pix_cnt reports the actual count.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3.
1. Good frame: vsync fall, frame_en=1, 3 lines of 4 pixels 0x10..0x1B -> 12 dInValid beats carrying 0x10..0x1B in order, each 1 cycle after input; frame_done one pulse 1 cycle after the 3rd href fall; pix_cnt=12; frame_err=0.
2. LINE_PAD_EN defined, line 2 has only 0x20,0x21 -> beats 0x20,0x21,0x00,0x00 with the pads on consecutive cycles after href fall; pix_cnt=12; frame_err=1.
3. Line 1 has 6 pixels 0x30..0x35 -> only 0x30..0x33 written; pix_cnt=12 at done; frame_err=1.
4. frame_en=0 at vsync fall, full frame driven -> no dInValid, busy=0 throughout, no frame_done; next frame with frame_en=1 behaves as scenario 1.
5. vsync rise after line 1 complete -> frame_done pulse, pix_cnt=4, frame_err=1, busy=0 afterwards.
6. rst pulsed mid line 2 -> all outputs 0 asynchronously; extra pixels before the next vsync fall are ignored; the following frame matches scenario 1.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// Camera-stream to frame-buffer write converter: exactly IMG_W*IMG_H raster-order beats per accepted frame.
// Build option LINE_PAD_EN: short lines are completed with PAD_VALUE beats instead of being truncated.
module pixel_frame_writer #(
   parameter int           IMG_W     = 640,
   parameter int           IMG_H     = 400,
   parameter logic [7:0]   PAD_VALUE = 8'h00
) (
   input  logic        clk0,
   input  logic        rst,
   input  logic        frame_en,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic        cam_de,
   input  logic [7:0]  cam_data,
   output logic [7:0]  dIn,
   output logic        dInValid,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err,
   output logic [17:0] pix_cnt
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_FULL = CW'(IMG_W);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef LINE_PAD_EN
   localparam logic [CW-1:0] COL_PAD_LAST = CW'(IMG_W - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
`ifdef LINE_PAD_EN
      , PAD
`endif
   } state_t;

   state_t          state, state_nxt;
   logic            vsync_d, href_d;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;

   logic vs_fall, vs_rise, hr_fall, px, col_full, row_last;
   logic start, wr_px, wr_pad, line_adv, err_evt;

   assign vs_fall  = vsync_d & ~cam_vsync;
   assign vs_rise  = ~vsync_d & cam_vsync;
   assign hr_fall  = href_d & ~cam_href;
   assign px       = cam_href & cam_de;
   assign col_full = (col == COL_FULL);
   assign row_last = (row == ROW_LAST);

   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         vsync_d <= 1'b0;
         href_d  <= 1'b0;
      end else begin
         state   <= state_nxt;
         vsync_d <= cam_vsync;
         href_d  <= cam_href;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (vs_fall && frame_en) state_nxt = ACTIVE;
         ACTIVE:
            if (vs_rise) state_nxt = DONE;
            else if (hr_fall) begin
`ifdef LINE_PAD_EN
               if (!col_full)     state_nxt = PAD;
               else if (row_last) state_nxt = DONE;
`else
               if (row_last) state_nxt = DONE;
`endif
            end
`ifdef LINE_PAD_EN
         PAD:
            if (vs_rise) state_nxt = DONE;
            else if (col == COL_PAD_LAST) state_nxt = row_last ? DONE : ACTIVE;
`endif
         DONE:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // Per-cycle action strobes; vsync rise preempts everything else in a capture state.
   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      start      = 1'b0;
      wr_px      = 1'b0;
      wr_pad     = 1'b0;
      line_adv   = 1'b0;
      err_evt    = 1'b0;
      case (state)
         IDLE:
            start = vs_fall & frame_en;
         ACTIVE: begin
            busy = 1'b1;
            if (vs_rise) err_evt = 1'b1;
            else begin
               wr_px = px & ~col_full;
               if (px && col_full) err_evt = 1'b1;
               if (hr_fall) begin
                  if (!col_full) err_evt = 1'b1;
`ifdef LINE_PAD_EN
                  line_adv = col_full;
`else
                  line_adv = 1'b1;
`endif
               end
            end
         end
`ifdef LINE_PAD_EN
         PAD: begin
            busy = 1'b1;
            if (vs_rise) err_evt = 1'b1;
            else begin
               wr_pad   = 1'b1;
               line_adv = (col == COL_PAD_LAST);
               if (px) err_evt = 1'b1;
            end
         end
`endif
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         dIn       <= 8'h00;
         dInValid  <= 1'b0;
         frame_err <= 1'b0;
         pix_cnt   <= 18'd0;
         col       <= '0;
         row       <= '0;
      end else begin
         dInValid <= 1'b0;
         if (start) begin
            col       <= '0;
            row       <= '0;
            pix_cnt   <= 18'd0;
            frame_err <= 1'b0;
         end
         if (wr_px) begin
            dIn      <= cam_data;
            dInValid <= 1'b1;
            col      <= col + 1'b1;
            pix_cnt  <= pix_cnt + 18'd1;
         end
         if (wr_pad) begin
            dIn      <= PAD_VALUE;
            dInValid <= 1'b1;
            col      <= col + 1'b1;
            pix_cnt  <= pix_cnt + 18'd1;
         end
         // Line advance overrides the column increment of the final pad beat.
         if (line_adv) begin
            col <= '0;
            row <= row + 1'b1;
         end
         if (err_evt) frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer with a 4x3 image; expectations follow LINE_PAD_EN.
module tb_pixel_frame_writer;

   logic        clk0 = 1'b0;
   logic        rst;
   logic        frame_en;
   logic        cam_vsync;
   logic        cam_href;
   logic        cam_de;
   logic [7:0]  cam_data;
   logic [7:0]  dIn;
   logic        dInValid;
   logic        busy;
   logic        frame_done;
   logic        frame_err;
   logic [17:0] pix_cnt;

   always #5 clk0 = ~clk0;

   pixel_frame_writer #(.IMG_W(4), .IMG_H(3), .PAD_VALUE(8'h00)) dut (
      .clk0(clk0), .rst(rst), .frame_en(frame_en), .cam_vsync(cam_vsync),
      .cam_href(cam_href), .cam_de(cam_de), .cam_data(cam_data),
      .dIn(dIn), .dInValid(dInValid), .busy(busy), .frame_done(frame_done),
      .frame_err(frame_err), .pix_cnt(pix_cnt)
   );

   int cyc = 0;
   always @(posedge clk0) cyc <= cyc + 1;

   logic [7:0] beats[$];
   int         beat_cyc[$];
   int         hf_cyc[$];
   int         done_cnt = 0;
   int         done_cyc = -1;
   bit         busy_seen = 1'b0;
   int         px_cyc0 = 0;
   int         n_vec = 0;
   int         n_err = 0;

   always @(posedge clk0) begin
      #1;
      if (dInValid === 1'b1) begin
         beats.push_back(dIn);
         beat_cyc.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic clr();
      beats.delete();
      beat_cyc.delete();
      hf_cyc.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      busy_seen = 1'b0;
   endtask

   task automatic start_frame(input logic en);
      @(negedge clk0);
      frame_en  = en;
      cam_vsync = 1'b0;
      repeat (2) @(negedge clk0);
   endtask

   task automatic send_line(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk0);
         if (i == 0) px_cyc0 = cyc + 1;
         cam_href = 1'b1;
         cam_de   = 1'b1;
         cam_data = base + 8'(i);
      end
      @(negedge clk0);
      cam_href = 1'b0;
      cam_de   = 1'b0;
      hf_cyc.push_back(cyc + 1);
      repeat (4) @(negedge clk0);
   endtask

   task automatic end_frame();
      @(negedge clk0);
      cam_vsync = 1'b1;
      repeat (3) @(negedge clk0);
   endtask

   task automatic check_beats(input string tag, input logic [7:0] exp_q[$]);
      logic [7:0] got;
      n_vec++;
      if (beats.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s beat_count got=%0d want=%0d", tag, beats.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         got = (i < beats.size()) ? beats[i] : 8'hxx;
         n_vec++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s beat[%0d] got=%h want=%h", tag, i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_en = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_de = 1'b0; cam_data = 8'h00;
      repeat (3) @(negedge clk0);
      n_vec += 6;
      if (dIn !== 8'h00)      begin n_err++; $display("FAIL reset_dIn got=%h want=00", dIn); end
      if (dInValid !== 1'b0)  begin n_err++; $display("FAIL reset_dInValid got=%b want=0", dInValid); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
      if (pix_cnt !== 18'd0)  begin n_err++; $display("FAIL reset_pix_cnt got=%0d want=0", pix_cnt); end
      rst = 1'b0;
      repeat (2) @(negedge clk0);
   endtask

   task automatic test_good_frame(input string tag, input logic [7:0] base);
      logic [7:0] exp_q[$];
      int p1;
      clr();
      start_frame(1'b1);
      send_line(base, 4);
      p1 = px_cyc0;
      send_line(base + 8'd4, 4);
      send_line(base + 8'd8, 4);
      end_frame();
      for (int i = 0; i < 12; i++) exp_q.push_back(base + 8'(i));
      check_beats(tag, exp_q);
      n_vec += 7;
      if (beat_cyc.size() < 12 || beat_cyc[0] != p1) begin
         n_err++; $display("FAIL %s first_beat_latency got_cyc=%0d want_cyc=%0d", tag,
                           (beat_cyc.size() > 0) ? beat_cyc[0] : -1, p1);
      end
      if (beat_cyc.size() < 12 || beat_cyc[3] != beat_cyc[0] + 3) begin
         n_err++; $display("FAIL %s beats_consecutive line0 not back-to-back", tag);
      end
      if (done_cnt != 1)        begin n_err++; $display("FAIL %s done_pulses got=%0d want=1", tag, done_cnt); end
      if (done_cyc != hf_cyc[2]) begin n_err++; $display("FAIL %s done_timing got_cyc=%0d want_cyc=%0d", tag, done_cyc, hf_cyc[2]); end
      if (pix_cnt !== 18'd12)   begin n_err++; $display("FAIL %s pix_cnt got=%0d want=12", tag, pix_cnt); end
      if (frame_err !== 1'b0)   begin n_err++; $display("FAIL %s frame_err got=%b want=0", tag, frame_err); end
      if (busy !== 1'b0)        begin n_err++; $display("FAIL %s busy_after got=%b want=0", tag, busy); end
   endtask

   task automatic test_short_line();
      logic [7:0] exp_q[$];
      clr();
      start_frame(1'b1);
      send_line(8'h10, 4);
      send_line(8'h20, 2);
      send_line(8'h18, 4);
      end_frame();
`ifdef LINE_PAD_EN
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h00, 8'h00, 8'h18, 8'h19, 8'h1A, 8'h1B};
      check_beats("short_pad", exp_q);
      n_vec += 3;
      if (pix_cnt !== 18'd12) begin n_err++; $display("FAIL short_pad pix_cnt got=%0d want=12", pix_cnt); end
      if (beat_cyc.size() < 8 || beat_cyc[6] != hf_cyc[1] + 1) begin
         n_err++; $display("FAIL short_pad pad0_timing want_cyc=%0d", hf_cyc[1] + 1);
      end
      if (beat_cyc.size() < 8 || beat_cyc[7] != hf_cyc[1] + 2) begin
         n_err++; $display("FAIL short_pad pad1_timing want_cyc=%0d", hf_cyc[1] + 2);
      end
`else
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h18, 8'h19, 8'h1A, 8'h1B};
      check_beats("short_trunc", exp_q);
      n_vec++;
      if (pix_cnt !== 18'd10) begin n_err++; $display("FAIL short_trunc pix_cnt got=%0d want=10", pix_cnt); end
`endif
      n_vec += 2;
      if (frame_err !== 1'b1) begin n_err++; $display("FAIL short frame_err got=%b want=1", frame_err); end
      if (done_cnt != 1)      begin n_err++; $display("FAIL short done_pulses got=%0d want=1", done_cnt); end
   endtask

   task automatic test_long_line();
      logic [7:0] exp_q[$];
      clr();
      start_frame(1'b1);
      send_line(8'h30, 6);
      send_line(8'h40, 4);
      send_line(8'h44, 4);
      end_frame();
      exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
      check_beats("long", exp_q);
      n_vec += 3;
      if (pix_cnt !== 18'd12) begin n_err++; $display("FAIL long pix_cnt got=%0d want=12", pix_cnt); end
      if (frame_err !== 1'b1) begin n_err++; $display("FAIL long frame_err got=%b want=1", frame_err); end
      if (done_cnt != 1)      begin n_err++; $display("FAIL long done_pulses got=%0d want=1", done_cnt); end
   endtask

   task automatic test_frame_skip();
      clr();
      start_frame(1'b0);
      send_line(8'h70, 4);
      send_line(8'h74, 4);
      send_line(8'h78, 4);
      end_frame();
      n_vec += 5;
      if (beats.size() != 0)  begin n_err++; $display("FAIL skip beats got=%0d want=0", beats.size()); end
      if (busy_seen)          begin n_err++; $display("FAIL skip busy_seen got=1 want=0"); end
      if (done_cnt != 0)      begin n_err++; $display("FAIL skip done_pulses got=%0d want=0", done_cnt); end
      if (pix_cnt !== 18'd12) begin n_err++; $display("FAIL skip pix_cnt_hold got=%0d want=12", pix_cnt); end
      if (frame_err !== 1'b1) begin n_err++; $display("FAIL skip frame_err_hold got=%b want=1", frame_err); end
      test_good_frame("skip_next", 8'h10);
   endtask

   task automatic test_early_end();
      clr();
      start_frame(1'b1);
      send_line(8'h50, 4);
      end_frame();
      n_vec += 5;
      if (beats.size() != 4)  begin n_err++; $display("FAIL early beats got=%0d want=4", beats.size()); end
      if (done_cnt != 1)      begin n_err++; $display("FAIL early done_pulses got=%0d want=1", done_cnt); end
      if (pix_cnt !== 18'd4)  begin n_err++; $display("FAIL early pix_cnt got=%0d want=4", pix_cnt); end
      if (frame_err !== 1'b1) begin n_err++; $display("FAIL early frame_err got=%b want=1", frame_err); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL early busy_after got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      clr();
      start_frame(1'b1);
      send_line(8'h60, 4);
      @(negedge clk0); cam_href = 1'b1; cam_de = 1'b1; cam_data = 8'h64;
      @(negedge clk0); cam_data = 8'h65;
      @(negedge clk0); cam_data = 8'h66;
      n_vec++;
      if (pix_cnt !== 18'd6) begin n_err++; $display("FAIL rstmid pix_cnt_before got=%0d want=6", pix_cnt); end
      #2 rst = 1'b1;
      #1;
      n_vec += 6;
      if (dIn !== 8'h00)       begin n_err++; $display("FAIL rstmid dIn got=%h want=00", dIn); end
      if (dInValid !== 1'b0)   begin n_err++; $display("FAIL rstmid dInValid got=%b want=0", dInValid); end
      if (busy !== 1'b0)       begin n_err++; $display("FAIL rstmid busy got=%b want=0", busy); end
      if (frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid frame_done got=%b want=0", frame_done); end
      if (frame_err !== 1'b0)  begin n_err++; $display("FAIL rstmid frame_err got=%b want=0", frame_err); end
      if (pix_cnt !== 18'd0)   begin n_err++; $display("FAIL rstmid pix_cnt got=%0d want=0", pix_cnt); end
      @(negedge clk0);
      rst = 1'b0;
      clr();
      @(negedge clk0); cam_data = 8'h67;
      @(negedge clk0); cam_data = 8'h68;
      @(negedge clk0); cam_href = 1'b0; cam_de = 1'b0;
      repeat (3) @(negedge clk0);
      end_frame();
      n_vec += 3;
      if (beats.size() != 0) begin n_err++; $display("FAIL rstmid beats_after got=%0d want=0", beats.size()); end
      if (done_cnt != 0)     begin n_err++; $display("FAIL rstmid done_after got=%0d want=0", done_cnt); end
      if (busy_seen)         begin n_err++; $display("FAIL rstmid busy_after got=1 want=0"); end
      test_good_frame("after_rst", 8'h10);
   endtask

   initial begin
      test_reset();
      test_good_frame("good", 8'h10);
      test_short_line();
      test_long_line();
      test_frame_skip();
      test_early_end();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
